dff_pipe: RTL and testbench
===========================

# dff_pipe

Parametrised elastic register pipeline: DEPTH stages of WIDTH-bit D flip-flops with asynchronous active-high reset. Each stage has its own valid bit. Ready/valid backpressure propagates stage by stage, so bubbles collapse and no data is lost or duplicated. It is the general-purpose successor to the single D flip-flop, used wherever the design needs a multi-cycle, stallable, flushable delay of a data bus.

## Interface
- WIDTH, 8, data width in bits (≥1)
- DEPTH, 3, number of register stages (≥1)
- RST_VAL, {WIDTH{1'b0}}, value loaded into every data stage on reset
- CW, $clog2(DEPTH+1), width of occupancy count (derived, not overridden)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- clr  in  1  synchronous flush, active-high
- in_valid  in  1  upstream data valid
- in_ready  out  1  pipeline can accept in_data this cycle
- in_data  in  WIDTH  upstream data
- out_valid  out  1  out_data holds a valid word
- out_ready  in  1  downstream accepts out_data this cycle
- out_data  out  WIDTH  data from last stage
- count  out  CW  number of stages currently holding valid data

## Operation
- State: data[i] (WIDTH) and v[i] (1) for i = 0..DEPTH-1; stage 0 is the input end, DEPTH-1 the output end.
- Ready chain, combinational: rdy[DEPTH] = out_ready; rdy[i] = !v[i] | rdy[i+1].
- in_ready = rdy[0] & !clr.
- Stage i loads from stage i-1 (or from the input for i = 0) when rdy[i] is 1:
  - v[i] <= v[i-1] (in_valid for i = 0)
  - data[i] <= data[i-1] only when the incoming valid is 1; otherwise data[i] holds.
- A stage with rdy[i] = 0 holds both data and valid.
- out_valid = v[DEPTH-1] & !clr; out_data = data[DEPTH-1].
- Transfer definitions: input transfer is in_valid & in_ready; output transfer is out_valid & out_ready.
- clr = 1: all v[i] <= 0 at the edge. data is unchanged. Neither input nor output transfers occur in that cycle.
- rst = 1: immediately (not waiting for an edge) all v[i] = 0 and all data[i] = RST_VAL. In_data is ignored while rst is high.
- count = popcount of the v vector. It is combinational from the flops and reflects state after the last edge.
- Ordering: words exit in acceptance order. No word is dropped unless clr or rst is applied.

## Timing
- Latency with out_ready held high: a word accepted in cycle n is on out_data with out_valid = 1 in cycle n+DEPTH-1+1, i.e. DEPTH cycles after acceptance.
- Throughput: one word per cycle, sustained with out_ready = 1.
- Full (count = DEPTH) and out_ready = 0: in_ready = 0.
- Full and out_ready = 1: in_ready = 1, so simultaneous in and out transfer occurs and count stays DEPTH.
- Empty (count = 0): out_valid = 0, in_ready = 1 (unless clr).
- Bubble collapse: a stall at the output lets upstream stages keep filling until every stage is valid.
- Reset values: out_valid = 0, out_data = RST_VAL, in_ready = 1 (if clr = 0), count = 0.
- Reset released mid-stream: the first in_valid after release is accepted on the first rising edge with rst low.
- clr and in_valid both high: in_valid is ignored, and count = 0 after the edge.
- DEPTH = 1: the block degenerates to a single registered slice with backpressure, and the same rules apply.

## Structure
- No shared-package typedefs are required. CW is a localparam computed inside the module.
- One sub-module: dff_pipe_stage (WIDTH, RST_VAL). It holds one data register and one valid flop with async reset, and has a load enable and a clear input.
- The top instantiates DEPTH stages in a generate loop and builds the rdy chain and popcount.

## Test plan
All cases use WIDTH=8, DEPTH=3, RST_VAL=8'hA5.
- Reset: assert rst mid-cycle -> out_valid=0, out_data=8'hA5, count=0 immediately, without a clock edge.
- Streaming: out_ready=1, send 8'h01..8'h05 on consecutive cycles -> same sequence on out, first word 3 cycles after acceptance, no gaps.
- Stall fill: out_ready=0, send 8'h10,8'h11,8'h12,8'h13 -> first three accepted, count=3, in_ready=0 on the 4th. Then out_ready=1 -> 8'h10,8'h11,8'h12,8'h13 emitted in order.
- Full with simultaneous in/out: count=3, out_ready=1, in_valid=1 with 8'h20 -> one out transfer and one in transfer in the same cycle, count stays 3.
- Clear: count=2, then clr=1 together with in_valid=1 and 8'h33 -> in_ready=0 and out_valid=0 that cycle, count=0 next cycle, 8'h33 never appears.
- Bubble: send 8'h40, idle 2 cycles, then send 8'h41, with out_ready=0 throughout -> both words are held in adjacent stages, count=2, and they exit in order once out_ready=1.

Source files
------------

// File: rtl/dff_pipe_pkg.sv
// Shared definitions for the elastic register pipeline.
// Default geometry and the per-stage control bundle.
package dff_pipe_pkg;

    localparam int DFF_PIPE_DEF_WIDTH = 8;
    localparam int DFF_PIPE_DEF_DEPTH = 3;

    typedef struct packed {
        logic load;
        logic clr;
    } stage_ctl_t;

endpackage

// File: rtl/dff_pipe_stage.sv
// One pipeline slice: a data register plus its valid flop.
// Data only moves when a valid word arrives, so bubbles never overwrite held data.
module dff_pipe_stage
    import dff_pipe_pkg::*;
#(
    parameter int               WIDTH   = DFF_PIPE_DEF_WIDTH,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  stage_ctl_t       ctl,
    input  logic             d_valid,
    input  logic [WIDTH-1:0] d_data,
    output logic             q_valid,
    output logic [WIDTH-1:0] q_data
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_valid <= 1'b0;
            q_data  <= RST_VAL;
        end else if (ctl.clr) begin
            // Flush drops the word but leaves the data register as it was.
            q_valid <= 1'b0;
        end else if (ctl.load) begin
            q_valid <= d_valid;
            if (d_valid) begin
                q_data <= d_data;
            end
        end
    end

endmodule

// File: rtl/dff_pipe.sv
// Elastic DEPTH-stage register pipeline with per-stage valid and ready/valid backpressure.
// Ready ripples from the output back to the input so bubbles collapse under a stall.
module dff_pipe
    import dff_pipe_pkg::*;
#(
    parameter int               WIDTH   = DFF_PIPE_DEF_WIDTH,
    parameter int               DEPTH   = DFF_PIPE_DEF_DEPTH,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    localparam int              CW      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    count
);

    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] data [DEPTH];
    logic [DEPTH:0]   rdy;
    logic [CW-1:0]    count_c;

    // A stage can take a word if it is empty or its successor is taking its word.
    always_comb begin
        rdy        = '0;
        rdy[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            rdy[i] = !v[i] | rdy[i+1];
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             stg_valid;
        logic [WIDTH-1:0] stg_data;
        stage_ctl_t       stg_ctl;

        if (i == 0) begin : g_head
            assign stg_valid = in_valid;
            assign stg_data  = in_data;
        end else begin : g_body
            assign stg_valid = v[i-1];
            assign stg_data  = data[i-1];
        end

        assign stg_ctl.load = rdy[i];
        assign stg_ctl.clr  = clr;

        dff_pipe_stage #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_VAL)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .ctl     (stg_ctl),
            .d_valid (stg_valid),
            .d_data  (stg_data),
            .q_valid (v[i]),
            .q_data  (data[i])
        );
    end

    always_comb begin
        count_c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count_c = count_c + CW'(v[i]);
        end
    end

    assign count     = count_c;
    assign in_ready  = rdy[0] & !clr;
    assign out_valid = v[DEPTH-1] & !clr;
    assign out_data  = data[DEPTH-1];

endmodule

// File: tb/tb_dff_pipe.sv
// Directed vector bench for dff_pipe (WIDTH=8, DEPTH=3, RST_VAL=8'hA5).
// Each vector row holds one cycle's inputs and the outputs expected before that cycle's edge.
module tb_dff_pipe;

    localparam int              WIDTH   = 8;
    localparam int              DEPTH   = 3;
    localparam logic [WIDTH-1:0] RST_VAL = 8'hA5;
    localparam int              CW      = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             clr;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       iv;
        logic [7:0] id;
        logic       ordy;
        logic       cl;
        logic       e_ir;
        logic       e_ov;
        logic [7:0] e_od;
        logic [1:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    dff_pipe #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .RST_VAL (RST_VAL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic iv, input logic [7:0] id, input logic ordy, input logic cl,
                       input logic e_ir, input logic e_ov, input logic [7:0] e_od,
                       input logic [1:0] e_cnt);
        vec_t t;
        t.iv = iv; t.id = id; t.ordy = ordy; t.cl = cl;
        t.e_ir = e_ir; t.e_ov = e_ov; t.e_od = e_od; t.e_cnt = e_cnt;
        vecs.push_back(t);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;

        //   iv  id     ordy clr  ir   ov   od     cnt
        // streaming 01..05
        add(1, 8'h01, 1, 0,   1, 0, 8'hA5, 0);
        add(1, 8'h02, 1, 0,   1, 0, 8'hA5, 1);
        add(1, 8'h03, 1, 0,   1, 0, 8'hA5, 2);
        add(1, 8'h04, 1, 0,   1, 1, 8'h01, 3);
        add(1, 8'h05, 1, 0,   1, 1, 8'h02, 3);
        add(0, 8'h00, 1, 0,   1, 1, 8'h03, 3);
        add(0, 8'h00, 1, 0,   1, 1, 8'h04, 2);
        add(0, 8'h00, 1, 0,   1, 1, 8'h05, 1);
        add(0, 8'h00, 0, 0,   1, 0, 8'h05, 0);
        // stall fill, then drain with simultaneous in/out at full
        add(1, 8'h10, 0, 0,   1, 0, 8'h05, 0);
        add(1, 8'h11, 0, 0,   1, 0, 8'h05, 1);
        add(1, 8'h12, 0, 0,   1, 0, 8'h05, 2);
        add(1, 8'h13, 0, 0,   0, 1, 8'h10, 3);
        add(1, 8'h13, 1, 0,   1, 1, 8'h10, 3);
        add(1, 8'h20, 1, 0,   1, 1, 8'h11, 3);
        add(0, 8'h00, 1, 0,   1, 1, 8'h12, 3);
        add(0, 8'h00, 1, 0,   1, 1, 8'h13, 2);
        add(0, 8'h00, 0, 0,   1, 1, 8'h20, 1);
        // clear with count=2 and a competing input word
        add(1, 8'h30, 0, 0,   1, 1, 8'h20, 1);
        add(1, 8'h33, 0, 1,   0, 0, 8'h20, 2);
        add(0, 8'h00, 1, 0,   1, 0, 8'h20, 0);
        // bubble collapse under stall
        add(1, 8'h40, 0, 0,   1, 0, 8'h20, 0);
        add(0, 8'h00, 0, 0,   1, 0, 8'h20, 1);
        add(0, 8'h00, 0, 0,   1, 0, 8'h20, 1);
        add(1, 8'h41, 0, 0,   1, 1, 8'h40, 1);
        add(0, 8'h00, 0, 0,   1, 1, 8'h40, 2);
        add(0, 8'h00, 0, 0,   1, 1, 8'h40, 2);
        add(0, 8'h00, 1, 0,   1, 1, 8'h40, 2);
        add(0, 8'h00, 1, 0,   1, 1, 8'h41, 1);
        add(0, 8'h00, 1, 0,   1, 0, 8'h41, 0);

        #2;
        check("reset_out_valid", {7'd0, out_valid}, 8'h00);
        check("reset_out_data", out_data, RST_VAL);
        check("reset_count", {6'd0, count}, 8'h00);
        check("reset_in_ready", {7'd0, in_ready}, 8'h01);
        #10;
        rst = 1'b0;

        foreach (vecs[k]) begin
            in_valid  = vecs[k].iv;
            in_data   = vecs[k].id;
            out_ready = vecs[k].ordy;
            clr       = vecs[k].cl;
            #1;
            check($sformatf("v%0d_in_ready", k), {7'd0, in_ready}, {7'd0, vecs[k].e_ir});
            check($sformatf("v%0d_out_valid", k), {7'd0, out_valid}, {7'd0, vecs[k].e_ov});
            check($sformatf("v%0d_out_data", k), out_data, vecs[k].e_od);
            check($sformatf("v%0d_count", k), {6'd0, count}, {6'd0, vecs[k].e_cnt});
            tick();
        end

        // Async reset mid-cycle with a word in flight
        in_valid = 1'b1; in_data = 8'h55; out_ready = 1'b0; clr = 1'b0;
        tick();
        in_valid = 1'b0;
        check("pre_rst_count", {6'd0, count}, 8'h01);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", {7'd0, out_valid}, 8'h00);
        check("async_rst_out_data", out_data, RST_VAL);
        check("async_rst_count", {6'd0, count}, 8'h00);
        check("async_rst_in_ready", {7'd0, in_ready}, 8'h01);

        // Input ignored while rst is held through an edge
        in_valid = 1'b1; in_data = 8'h66;
        tick();
        check("rst_held_count", {6'd0, count}, 8'h00);
        check("rst_held_out_data", out_data, RST_VAL);

        // Release mid-cycle; first word taken on the next edge, out 3 cycles later
        #3;
        rst = 1'b0; in_valid = 1'b1; in_data = 8'h77; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("post_rst_accept_count", {6'd0, count}, 8'h01);
        check("post_rst_out_valid_early", {7'd0, out_valid}, 8'h00);
        tick();
        check("post_rst_out_valid_mid", {7'd0, out_valid}, 8'h00);
        tick();
        check("post_rst_out_valid", {7'd0, out_valid}, 8'h01);
        check("post_rst_out_data", out_data, 8'h77);
        tick();
        check("post_rst_drained", {6'd0, count}, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
